fsm_start_ctrl: RTL
===================

# fsm_start_ctrl

Trigger and supervision stage directly upstream of the write/read check state machine (`fsm_1`). It turns a raw push-button, or an optional free-running timer, into clean one-cycle `write_start` pulses for `fsm_1`. It also watches the `error_flag` that `fsm_1` returns, and counts and latches failures for board LEDs. Auto-repeat stops on the first error, so the failing pattern stays observable.

## Interface
- `CNT_DB`, default 1_000_000: debounce length in cycles (20 ms at 50 MHz); must be ≥ 2.
- `AUTO_PERIOD`, default 50_000_000: auto-trigger interval in cycles; must be > `LOCKOUT`.
- `LOCKOUT`, default 1024: minimum cycles from one `write_start` pulse to the next.
- `sclk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `key_in` in 1: raw push-button; asynchronous; active-low (pressed = 0).
- `auto_en` in 1: enables periodic triggering; quasi-static; treated as synchronous.
- `error_flag` in 1: check-failure level from `fsm_1`; synchronous to `sclk`.
- `write_start` out 1: one-cycle start pulse to `fsm_1`.
- `busy` out 1: high while the lockout counter is running.
- `err_led` out 1: sticky error indicator.
- `err_cnt` out 8: count of `error_flag` rising edges; saturates at 255.

## Operation
**Key path**
- `key_in` passes through a 2-flop synchronizer; its output is `key_s`.
- Debounce FSM states:
  - IDLE → DB_PRESS when `key_s`=0; the debounce counter clears.
  - DB_PRESS: counter increments each cycle `key_s`=0. `key_s`=1 → back to IDLE. When the counter reaches `CNT_DB`−1 → PRESSED and raise `key_evt` for one cycle.
  - PRESSED → DB_REL when `key_s`=1; counter clears.
  - DB_REL: counter increments each cycle `key_s`=1. `key_s`=0 → back to PRESSED. When the counter reaches `CNT_DB`−1 → IDLE.
- A held key therefore produces exactly one `key_evt`.

**Auto path**
- The period counter runs only while `auto_en`=1 and `err_led`=0. Otherwise it holds at 0.
- The counter wraps at `AUTO_PERIOD`−1 and raises `auto_evt` for one cycle on the wrap.
- Every `write_start` pulse also resets the period counter to 0, so a key press re-phases the timer.

**Trigger arbitration**
- trigger = (`key_evt` | `auto_evt`) & !`busy`.
- `key_evt` and `auto_evt` in the same cycle produce one pulse.
- A trigger during `busy` is dropped, not queued.
- On a trigger, `write_start`=1 for exactly one cycle and the lockout counter loads `LOCKOUT`−1.
- `busy`=1 while the lockout counter is nonzero. It decrements to 0, so `busy` stays high for `LOCKOUT`−1 cycles after the pulse cycle.

**Error path**
- `error_flag` is registered once (`err_q`). Rising edge = `error_flag` & !`err_q`.
- On a rising edge: `err_cnt` += 1 (held at 255 once reached) and `err_led` ← 1.
- A level held high counts once. Only `rst` clears `err_led` and `err_cnt`.
- With `err_led` high, auto triggering stops; key triggering still works.

## Timing
- Reset values: `write_start`=0, `busy`=0, `err_led`=0, `err_cnt`=0. FSM in IDLE, all counters 0, synchronizer flops at 1 (released).
- Press latency: `key_in` first sampled 0 at edge N and held low, with no lockout active → `write_start` high during the cycle after edge N+`CNT_DB`+2, then low on the next edge.
- Auto: with `auto_en` rising at edge M, no errors and no key activity, pulses occur every `AUTO_PERIOD` cycles. The first pulse is at edge M+`AUTO_PERIOD`.
- Error latency: `err_led` and `err_cnt` update on the edge after the first cycle `error_flag` is sampled 1.
- `rst` asserted mid-operation takes effect on the next edge. Any pulse in flight is cut, and the key must be re-debounced from IDLE after release.
- `auto_en` dropping mid-period clears the period counter on the next edge.

## Structure
- Package `fsm_start_pkg` holds:
  - debounce state enum (IDLE, DB_PRESS, PRESSED, DB_REL), 2-bit binary encoding;
  - `ERR_CNT_W`=8;
  - width helper: `$clog2` of each parameter.
- Sub-module `key_debounce`: synchronizer, debounce FSM, `key_evt` output. The top level holds the auto timer, arbitration, lockout and error logic.

## Test plan
Bench parameters: `CNT_DB`=4, `AUTO_PERIOD`=50, `LOCKOUT`=10.

1. Reset, then `key_in` low at edge 10 held for 100 cycles → single `write_start` pulse at cycle after edge 16; no further pulses; `busy` high 9 cycles.
2. `key_in` bounce: low 2 cycles, high 1, low 2, high → no pulse. Then low 20 cycles → exactly one pulse.
3. `auto_en`=1 from edge 0 → pulses at edges 50, 100, 150. A key press timed so its `key_evt` coincides with edge 100 → one pulse only.
4. `key_evt` 5 cycles after an auto pulse → dropped. Next auto pulse still occurs 50 cycles after the previous one.
5. `error_flag` high 3 cycles, low, high 1 → `err_cnt`=2, `err_led`=1, auto pulses stop. A key press still yields a pulse. Drive 300 rising edges → `err_cnt`=255.
6. Assert `rst` during DB_PRESS and during `busy` → all outputs reset values next edge; no pulse while `key_in` stays held low through the reset.

Source files
------------

// File: rtl/fsm_start_pkg.sv
// Shared types and sizing helpers for the fsm_1 start/supervision stage.
package fsm_start_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DB_PRESS = 2'd1,
      PRESSED  = 2'd2,
      DB_REL   = 2'd3
   } db_state_t;

   localparam int ERR_CNT_W = 8;

   // Counter width for a count range of n; never below one bit.
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button synchronizer and debounce FSM; emits one key_evt per debounced press.
module key_debounce
   import fsm_start_pkg::*;
#(
   parameter int CNT_DB = 1_000_000
) (
   input  logic i_sclk,
   input  logic i_rst,
   input  logic i_key_in,
   output logic o_key_evt
);

   localparam int              DBW      = cnt_w(CNT_DB);
   localparam logic [DBW-1:0]  CNT_LAST = DBW'(CNT_DB - 1);

   logic           r_sync1;
   logic           r_key_s;
   logic           r_armed;
   logic           w_armed_nxt;
   db_state_t      r_state;
   db_state_t      w_state_nxt;
   logic [DBW-1:0] r_cnt;
   logic [DBW-1:0] w_cnt_nxt;
   logic           w_cnt_last;

   assign w_cnt_last = (r_cnt == CNT_LAST);

   always_ff @(posedge i_sclk) begin
      if (i_rst) begin
         r_sync1 <= 1'b1;
         r_key_s <= 1'b1;
      end else begin
         r_sync1 <= i_key_in;
         r_key_s <= r_sync1;
      end
   end

   always_ff @(posedge i_sclk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_armed <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_armed <= w_armed_nxt;
      end
   end

   // After reset the key must first be seen released (both sync flops high) for
   // CNT_DB cycles, so a key held through reset never fires.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_armed_nxt = r_armed;
      case (r_state)
         IDLE: begin
            if (!r_armed) begin
               if (r_key_s && r_sync1) begin
                  if (w_cnt_last) w_armed_nxt = 1'b1;
                  else            w_cnt_nxt   = r_cnt + DBW'(1);
               end else begin
                  w_cnt_nxt = '0;
               end
            end else if (!r_key_s) begin
               w_state_nxt = DB_PRESS;
               w_cnt_nxt   = '0;
            end
         end
         DB_PRESS: begin
            if (r_key_s)         w_state_nxt = IDLE;
            else if (w_cnt_last) w_state_nxt = PRESSED;
            else                 w_cnt_nxt   = r_cnt + DBW'(1);
         end
         PRESSED: begin
            if (r_key_s) begin
               w_state_nxt = DB_REL;
               w_cnt_nxt   = '0;
            end
         end
         DB_REL: begin
            if (!r_key_s)        w_state_nxt = PRESSED;
            else if (w_cnt_last) w_state_nxt = IDLE;
            else                 w_cnt_nxt   = r_cnt + DBW'(1);
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_key_evt = (r_state == DB_PRESS) && !r_key_s && w_cnt_last;
   end

endmodule

// File: rtl/fsm_start_ctrl.sv
// Start-pulse generator for fsm_1: key/auto trigger arbitration, lockout and error latching.
module fsm_start_ctrl
   import fsm_start_pkg::*;
#(
   parameter int CNT_DB      = 1_000_000,
   parameter int AUTO_PERIOD = 50_000_000,
   parameter int LOCKOUT     = 1024
) (
   input  logic                 sclk,
   input  logic                 rst,
   input  logic                 key_in,
   input  logic                 auto_en,
   input  logic                 error_flag,
   output logic                 write_start,
   output logic                 busy,
   output logic                 err_led,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   localparam int             PW        = cnt_w(AUTO_PERIOD);
   localparam int             LW        = cnt_w(LOCKOUT);
   localparam logic [PW-1:0]  PER_LAST  = PW'(AUTO_PERIOD - 1);
   localparam logic [LW-1:0]  LOCK_LOAD = LW'(LOCKOUT - 1);

   logic                 w_key_evt;
   logic                 w_auto_run;
   logic                 w_auto_evt;
   logic                 w_trig;
   logic                 w_err_rise;
   logic [PW-1:0]        r_per_cnt;
   logic [LW-1:0]        r_lock;
   logic                 r_write_start;
   logic                 r_err_q;
   logic                 r_err_led;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   key_debounce #(.CNT_DB(CNT_DB)) u_key_debounce (
      .i_sclk    (sclk),
      .i_rst     (rst),
      .i_key_in  (key_in),
      .o_key_evt (w_key_evt)
   );

   assign w_auto_run = auto_en & ~r_err_led;
   assign w_auto_evt = w_auto_run & (r_per_cnt == PER_LAST);
   assign w_trig     = (w_key_evt | w_auto_evt) & ~busy;
   assign w_err_rise = error_flag & ~r_err_q;

   // Cleared on every accepted trigger so a key press re-phases the timer.
   always_ff @(posedge sclk) begin
      if (rst)                                    r_per_cnt <= '0;
      else if (!w_auto_run || w_trig || w_auto_evt) r_per_cnt <= '0;
      else                                        r_per_cnt <= r_per_cnt + PW'(1);
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         r_lock        <= '0;
         r_write_start <= 1'b0;
      end else begin
         r_write_start <= w_trig;
         if (w_trig)            r_lock <= LOCK_LOAD;
         else if (r_lock != '0) r_lock <= r_lock - LW'(1);
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         r_err_q   <= 1'b0;
         r_err_led <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err_q <= error_flag;
         if (w_err_rise) begin
            r_err_led <= 1'b1;
            if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
         end
      end
   end

   assign busy        = (r_lock != '0);
   assign write_start = r_write_start;
   assign err_led     = r_err_led;
   assign err_cnt     = r_err_cnt;

endmodule
